// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// Widths are fixed at 32-bit address and 32-bit data.
interface mem_responder_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressed, big-endian word memory answering one request at a time
// after a fixed LATENCY, with misaligned/out-of-range requests flagged.
module mem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);
  localparam int unsigned IW        = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int unsigned CW        = 4;
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;

  logic          r_req_ready;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;

  logic [7:0]    r_mem [DEPTH_BYTES];

  logic          w_accept;
  logic          w_commit;
  logic          w_complete;
  logic          w_err;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_rword;

  assign w_err   = (r_addr[1:0] != 2'b00) || (r_addr > LAST_WORD);
  assign w_idx   = r_addr[IW-1:0];
  assign w_rword = {r_mem[w_idx], r_mem[w_idx + IW'(1)],
                    r_mem[w_idx + IW'(2)], r_mem[w_idx + IW'(3)]};

  // Next-state and counter control
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_commit   = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept   = 1'b1;
          w_next     = BUSY;
          w_cnt_next = CW'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request is frozen at the accept edge; later bus activity is ignored
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Ready is registered, so it reappears one cycle after the response completes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_next == IDLE);
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (!w_err && !r_write) ? w_rword : '0;
      end else if (w_complete) begin
        r_resp_valid <= 1'b0;
        r_resp_err   <= 1'b0;
        r_resp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit && r_write && !w_err) begin
      r_mem[w_idx]          <= r_wdata[31:24];
      r_mem[w_idx + IW'(1)] <= r_wdata[23:16];
      r_mem[w_idx + IW'(2)] <= r_wdata[15:8];
      r_mem[w_idx + IW'(3)] <= r_wdata[7:0];
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: byte-array reference model feeds a
// queue of expected responses that is popped as each response appears.
module tb_mem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0] m_mem [DEPTH];
  exp_t       sb [$];

  mem_responder_if bus ();

  mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 8'h00;
  endtask

  task automatic scramble();
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_write = 1'($urandom_range(1));
  endtask

  // One full transaction: accept, latency check, optional hold, completion
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int hold, input bit scr);
    exp_t e;
    exp_t got;
    int   waitc = 0;
    int   cyc   = 0;
    @(negedge clk);
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    e.err   = (a[1:0] != 2'b00) || (a > 32'(DEPTH - 4));
    e.rdata = '0;
    if (!e.err) begin
      if (w) begin
        m_mem[a]   = d[31:24];
        m_mem[a+1] = d[23:16];
        m_mem[a+2] = d[15:8];
        m_mem[a+3] = d[7:0];
      end else begin
        e.rdata = {m_mem[a], m_mem[a+1], m_mem[a+2], m_mem[a+3]};
      end
    end
    sb.push_back(e);
    @(negedge clk);
    if (scr) scramble(); else bus.req_valid = 1'b0;
    while (!bus.resp_valid && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (scr) scramble();
    end
    chk({tag, "/latency"}, 32'(cyc), 32'(LAT));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, "/rdata"}, bus.resp_rdata, got.rdata);
      chk({tag, "/err"}, 32'(bus.resp_err), 32'(got.err));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        if (scr) scramble();
        chk({tag, "/hold_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "/hold_rdata"}, bus.resp_rdata, got.rdata);
        chk({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, "/done_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "/done_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "/done_err"}, 32'(bus.resp_err), 32'd0);
    chk({tag, "/done_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    model_clear();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Last valid word reads zero after reset
    txn("ld_3fc_zero", 1'b0, 32'h3FC, 32'h0, 0, 1'b0);

    // Store/load round trip, big-endian, with a held response
    txn("st_10", 1'b1, 32'h10, 32'h12345678, 2, 1'b0);
    txn("ld_10", 1'b0, 32'h10, 32'h0, 5, 1'b0);
    chk("byte_10", 32'(m_mem[32'h10]), 32'h12);
    txn("st_3fc", 1'b1, 32'h3FC, 32'hA1B2C3D4, 0, 1'b0);
    txn("ld_3fc", 1'b0, 32'h3FC, 32'h0, 0, 1'b0);

    // Rejected requests leave storage untouched
    txn("ld_3", 1'b0, 32'h3, 32'h0, 0, 1'b0);
    txn("ld_400", 1'b0, 32'h400, 32'h0, 0, 1'b0);
    txn("st_402", 1'b1, 32'h402, 32'hFFFFFFFF, 0, 1'b0);
    txn("st_12", 1'b1, 32'h12, 32'hFFFFFFFF, 0, 1'b0);
    txn("ld_0", 1'b0, 32'h0, 32'h0, 0, 1'b0);
    txn("ld_10_again", 1'b0, 32'h10, 32'h0, 0, 1'b0);
    txn("ld_3fc_again", 1'b0, 32'h3FC, 32'h0, 0, 1'b0);

    // Inputs wiggle after accept; only captured values matter
    txn("st_40_scr", 1'b1, 32'h40, 32'hCAFEF00D, 3, 1'b1);
    txn("ld_40_scr", 1'b0, 32'h40, 32'h0, 3, 1'b1);
    txn("ld_44", 1'b0, 32'h44, 32'h0, 0, 1'b0);

    // Reset while BUSY discards the pending store
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("busy_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("busy_rst_rdata", bus.resp_rdata, 32'd0);
    chk("busy_rst_err", 32'(bus.resp_err), 32'd0);
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_rst_rel_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("busy_rst_no_resp", 32'(bus.resp_valid), 32'd0);
    txn("ld_20_after_rst", 1'b0, 32'h20, 32'h0, 0, 1'b0);
    txn("ld_10_after_rst", 1'b0, 32'h10, 32'h0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
